// File: rtl/phase_gen_pkg.sv
// phase_gen shared types: FSM state encoding and
// the phase-count clamp used when loading len.
package phase_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned maxp
  );
    if (len == 0 || len > maxp) begin
      return maxp;
    end
    return len;
  endfunction

endpackage

// File: rtl/phase_gen_if.sv
// Control/status bundle between the sequencer driver
// (master) and the phase generator (slave).
interface phase_gen_if #(
  parameter int MAX_PHASES = 8,
  parameter int LEN_W      = $clog2(MAX_PHASES + 1)
);
  logic                  run;
  logic                  stall;
  logic [LEN_W-1:0]      len;
  logic                  step_mode;
  logic                  step;
  logic                  halt;
  logic                  resume;
  logic [MAX_PHASES-1:0] T;
  logic [LEN_W-1:0]      phase;
  logic                  instr_start;
  logic                  instr_done;
  logic                  halted;
  logic [1:0]            state;

  modport master (
    output run, stall, len, step_mode,
    output step, halt, resume,
    input  T, phase, instr_start,
    input  instr_done, halted, state
  );

  modport slave (
    input  run, stall, len, step_mode,
    input  step, halt, resume,
    output T, phase, instr_start,
    output instr_done, halted, state
  );
endinterface

// File: rtl/phase_onehot_dec.sv
// Binary phase index to one-hot beat vector.
// Out-of-range indices decode to all zeros.
module phase_onehot_dec #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [W-1:0] i_phase,
  output logic [N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = (i_phase == W'(i));
    end
  end

endmodule

// File: rtl/phase_gen.sv
// CPU beat generator: one-hot phase vector with
// per-instruction length, stall, step and halt.
import phase_gen_pkg::*;

module phase_gen #(
  parameter int MAX_PHASES = 8,
  parameter int LEN_W      = $clog2(MAX_PHASES + 1)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  phase_gen_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_phase;
  logic [LEN_W-1:0]      w_phase_nxt;
  logic [LEN_W-1:0]      r_len_q;
  logic [LEN_W-1:0]      w_len_nxt;
  logic                  r_pend;
  logic                  w_pend_nxt;
  logic                  r_start;
  logic                  r_halted;
  logic [MAX_PHASES-1:0] r_T;
  logic [MAX_PHASES-1:0] w_onehot;
  logic                  w_last;
  logic                  w_halt_any;
  logic                  w_load;
  logic                  w_run_nxt;

  assign w_last     = (r_phase == r_len_q - LEN_W'(1));
  assign w_halt_any = r_pend | bus.halt;
  assign w_run_nxt  = (w_state_nxt == RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_len_nxt   = r_len_q;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_halt_any)   w_state_nxt = HALTED;
        else if (bus.run) w_load      = 1'b1;
      end
      STEP_WAIT: begin
        if (w_halt_any)    w_state_nxt = HALTED;
        else if (bus.step) w_load      = 1'b1;
      end
      HALTED: begin
        if (bus.resume) w_load = 1'b1;
      end
      RUN: begin
        if (!bus.stall) begin
          if (!w_last)            w_phase_nxt = r_phase + LEN_W'(1);
          else if (w_halt_any)    w_state_nxt = HALTED;
          else if (!bus.run)      w_state_nxt = IDLE;
          else if (bus.step_mode) w_state_nxt = STEP_WAIT;
          else                    w_load      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_state_nxt = RUN;
      w_phase_nxt = '0;
      w_len_nxt   = LEN_W'(clamp_len(32'(bus.len), MAX_PHASES));
    end
    if (w_state_nxt != RUN) w_phase_nxt = '0;
    // pending halt is consumed by entering HALTED; ignored while halted
    w_pend_nxt = r_pend;
    if (w_state_nxt == HALTED)             w_pend_nxt = 1'b0;
    else if (bus.halt && r_state != HALTED) w_pend_nxt = 1'b1;
  end

  phase_onehot_dec #(
    .N (MAX_PHASES),
    .W (LEN_W)
  ) u_dec (
    .i_phase  (w_phase_nxt),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_len_q  <= LEN_W'(MAX_PHASES);
      r_pend   <= 1'b0;
      r_T      <= '0;
      r_start  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_len_q  <= w_len_nxt;
      r_pend   <= w_pend_nxt;
      r_T      <= w_run_nxt ? w_onehot : '0;
      r_start  <= w_run_nxt && (w_phase_nxt == '0);
      r_halted <= (w_state_nxt == HALTED);
    end
  end

  assign bus.T           = r_T;
  assign bus.phase       = r_phase;
  assign bus.instr_start = r_start;
  assign bus.instr_done  = (r_state == RUN) && w_last && !bus.stall;
  assign bus.halted      = r_halted;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: beat patterns, stall,
// back-to-back, step, halt/resume and mid-instruction reset.
module tb_phase_gen;

  localparam int MP = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  phase_gen_if #(.MAX_PHASES(MP)) bus();

  phase_gen #(.MAX_PHASES(MP)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] e1_t [6]  = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
  logic       e1_d [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] e2_t [7]  = '{8'h01, 8'h02, 8'h04, 8'h04, 8'h04, 8'h08, 8'h10};
  logic       e2_d [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] e3_t [10] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h04,
                            8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] e3_p [10] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2,
                            4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
  logic       e3_s [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #2;
  endtask

  initial begin
    bus.run = 0; bus.stall = 0; bus.len = '0; bus.step_mode = 0;
    bus.step = 0; bus.halt = 0; bus.resume = 0;
    cyc(); cyc(); #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_T", 32'(bus.T), 32'h0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_start", 32'(bus.instr_start), 32'd0);
    chk("rst_done", 32'(bus.instr_done), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);

    sys_rst = 0; bus.run = 1; bus.len = 4'd3;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 3) bus.len = 4'd5;
      #1;
      chk("len3_T", 32'(bus.T), 32'(e1_t[i]));
      chk("len3_done", 32'(bus.instr_done), 32'(e1_d[i]));
    end

    for (int i = 0; i < 7; i++) begin
      cyc();
      bus.stall = (i == 2 || i == 3);
      if (i == 1) bus.len = 4'd2;
      #1;
      chk("stall_T", 32'(bus.T), 32'(e2_t[i]));
      chk("stall_done", 32'(bus.instr_done), 32'(e2_d[i]));
    end
    bus.stall = 0;

    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 0) bus.len = 4'd0;
      if (i == 9) begin
        bus.step_mode = 1; bus.len = 4'd4;
      end
      #1;
      chk("b2b_T", 32'(bus.T), 32'(e3_t[i]));
      chk("b2b_phase", 32'(bus.phase), 32'(e3_p[i]));
      chk("b2b_start", 32'(bus.instr_start), 32'(e3_s[i]));
      chk("b2b_done", 32'(bus.instr_done), 32'(i == 1 || i == 9));
    end

    cyc(); #1;
    chk("sw_state", 32'(bus.state), 32'd2);
    chk("sw_T", 32'(bus.T), 32'h0);
    bus.step = 1;
    cyc(); bus.step = 0; #1;
    chk("step_T0", 32'(bus.T), 32'h01);
    chk("step_start", 32'(bus.instr_start), 32'd1);
    cyc(); bus.step = 1; #1;
    chk("step_T1", 32'(bus.T), 32'h02);
    cyc(); bus.step = 0; #1;
    chk("step_T2", 32'(bus.T), 32'h04);
    cyc(); #1;
    chk("step_T3", 32'(bus.T), 32'h08);
    chk("step_done", 32'(bus.instr_done), 32'd1);
    cyc(); #1;
    chk("step_back_state", 32'(bus.state), 32'd2);
    chk("step_back_T", 32'(bus.T), 32'h0);
    cyc(); #1;
    chk("step_wait_hold", 32'(bus.state), 32'd2);

    bus.step_mode = 0; bus.len = 4'd4; bus.step = 1;
    cyc(); bus.step = 0; #1;
    chk("halt_T0", 32'(bus.T), 32'h01);
    cyc(); bus.halt = 1; #1;
    chk("halt_T1", 32'(bus.T), 32'h02);
    cyc(); bus.halt = 0; #1;
    chk("halt_T2", 32'(bus.T), 32'h04);
    cyc(); #1;
    chk("halt_T3", 32'(bus.T), 32'h08);
    chk("halt_not_yet", 32'(bus.halted), 32'd0);
    chk("halt_done", 32'(bus.instr_done), 32'd1);
    cyc(); #1;
    chk("halted", 32'(bus.halted), 32'd1);
    chk("halted_state", 32'(bus.state), 32'd3);
    chk("halted_T", 32'(bus.T), 32'h0);
    cyc(); #1;
    chk("halted_hold", 32'(bus.halted), 32'd1);
    bus.resume = 1; bus.halt = 1; bus.len = 4'd6;
    cyc(); bus.resume = 0; bus.halt = 0; #1;
    chk("resume_T", 32'(bus.T), 32'h01);
    chk("resume_state", 32'(bus.state), 32'd1);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    cyc(); #1;
    chk("len6_T1", 32'(bus.T), 32'h02);
    cyc(); bus.halt = 1; #1;
    chk("len6_T2", 32'(bus.T), 32'h04);
    cyc(); bus.halt = 0; sys_rst = 1; #1;
    chk("len6_T3", 32'(bus.T), 32'h08);
    chk("len6_phase3", 32'(bus.phase), 32'd3);
    cyc(); sys_rst = 0; bus.run = 0; #1;
    chk("mrst_state", 32'(bus.state), 32'd0);
    chk("mrst_T", 32'(bus.T), 32'h0);
    chk("mrst_phase", 32'(bus.phase), 32'd0);
    chk("mrst_start", 32'(bus.instr_start), 32'd0);
    chk("mrst_halted", 32'(bus.halted), 32'd0);
    chk("mrst_done", 32'(bus.instr_done), 32'd0);
    cyc(); #1;
    chk("mrst_pend_clr", 32'(bus.state), 32'd0);

    bus.run = 1; bus.len = 4'd1;
    cyc(); #1;
    chk("len1_T", 32'(bus.T), 32'h01);
    chk("len1_start", 32'(bus.instr_start), 32'd1);
    chk("len1_done", 32'(bus.instr_done), 32'd1);
    cyc(); bus.run = 0; #1;
    chk("len1b_T", 32'(bus.T), 32'h01);
    chk("len1b_start", 32'(bus.instr_start), 32'd1);
    chk("len1b_done", 32'(bus.instr_done), 32'd1);
    cyc(); bus.halt = 1; #1;
    chk("runoff_state", 32'(bus.state), 32'd0);
    chk("runoff_T", 32'(bus.T), 32'h0);
    cyc(); bus.halt = 0; #1;
    chk("idle_halt_state", 32'(bus.state), 32'd3);
    chk("idle_halt_flag", 32'(bus.halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_gen.md
# phase_gen

Parametrised CPU beat generator: produces a registered one-hot phase vector T[MAX_PHASES-1:0] that sequences instruction execution in the control unit. Generalises the fixed three-beat T1/T2/T3 counter. Adds per-instruction phase count, stall, single-step, halt/resume, and instruction start/done strobes. Sits between the clock/reset source and the control-signal decoder.

## Interface
- MAX_PHASES, 8, maximum phases per instruction; legal range is 2 to 16.
- LEN_W, $clog2(MAX_PHASES+1), width of `len`.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- run  in  LEN_W? no: 1  level; enables instruction issue from IDLE.
- stall  in  1  level; freezes the current phase.
- len  in  LEN_W  phase count for the next instruction.
- step_mode  in  1  level; selects single-instruction stepping.
- step  in  1  pulse; releases one instruction in STEP_WAIT.
- halt  in  1  pulse; requests a halt at the next instruction boundary.
- resume  in  1  pulse; leaves HALTED.
- T  out  MAX_PHASES  one-hot active phase, registered; all zeros when not running.
- phase  out  LEN_W  binary index of the active phase, registered.
- instr_start  out  1  high during phase 0 while running.
- instr_done  out  1  high on the last phase when `stall`=0; combinational from `stall`.
- halted  out  1  registered; high in HALTED.
- state  out  2  current FSM state, for debug.

## Operation
- FSM states are IDLE, RUN, STEP_WAIT and HALTED.
- IDLE: T=0. When `run`=1, the block loads `len` and enters RUN at phase 0.
- STEP_WAIT: T=0. When `step`=1, the block loads `len` and enters RUN at phase 0.
- HALTED: T=0. When `resume`=1, the block loads `len` and enters RUN at phase 0.
- RUN, `stall`=1: `T`, `phase` and `len_q` hold.
- RUN, `stall`=0, phase < len_q-1: phase increments and T shifts left by one.
- RUN, `stall`=0, phase = len_q-1 (boundary): `instr_done` pulses. The next state is chosen by priority:
  1. halt pending → HALTED
  2. `run`=0 → IDLE
  3. `step_mode`=1 → STEP_WAIT
  4. otherwise phase 0 with a fresh `len` load (back-to-back, no bubble)
- `len` is sampled only on a transition into phase 0 and is then held in `len_q` for the whole instruction.
- `len`=0 or `len` > MAX_PHASES loads MAX_PHASES.
- `len`=1 gives a one-cycle instruction: `instr_start` and `instr_done` are high together.
- halt pending is a sticky flag:
  - set by `halt`=1 in any state except HALTED;
  - cleared on entering HALTED;
  - in IDLE or STEP_WAIT, the block goes directly to HALTED on the next edge.
- `run` dropping mid-instruction does not abort; the instruction finishes.
- `step` while in RUN is ignored.
- Same-cycle `halt` and `resume` in HALTED: `resume` wins.
- Same-cycle `halt` and boundary: the halt is taken at that boundary.
- Reset (applies at any time, including mid-instruction):
  - state=IDLE, T=0, phase=0, len_q=MAX_PHASES, halt pending=0;
  - instr_start=0, instr_done=0, halted=0;
  - takes effect on the next edge.

## Timing
- Start latency: `run`/`step`/`resume` sampled high at edge k → T[0]=1 after edge k.
- Each unstalled phase lasts exactly 1 cycle.
- An instruction takes len_q + (number of stall cycles) cycles.
- Back-to-back instructions: T[len_q-1] is followed by T[0] on the next cycle; there are zero idle cycles.
- `halted` rises one cycle after the boundary phase.
- `instr_done` depends combinationally on `stall` in the same cycle. All other outputs are flop outputs.

## Structure
- Package phase_gen_pkg holds:
  - the state_t enum (IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3);
  - a clamp function for `len`.
- Sub-module phase_onehot_dec (binary `phase` → one-hot `T`). It is instantiated once; alternatively, T is kept as its own shift register and must be proven equivalent.

## Test plan
- MAX_PHASES=8, len=3, run tied to 1, reset released → T cycles 001,010,100,001…; instr_done is high every third cycle; this matches the legacy T1/T2/T3 pattern.
- len=5, stall high for 2 cycles during phase 2 → T[2] is held for 3 cycles; the instruction takes 7 cycles; instr_done occurs exactly once.
- Back-to-back len=2 then len=0 → phases 0,1, then 0..7 with no gap; instr_start is high on both phase-0 cycles.
- step_mode=1, step pulse → exactly one len=4 instruction, then STEP_WAIT with T=0; a step pulse during RUN is ignored.
- halt pulsed at phase 1 of a len=4 instruction → phases 2 and 3 complete; halted=1 the next cycle; resume → T[0] one cycle later.
- sys_rst=1 at phase 3 of a len=6 instruction → next cycle state=IDLE, T=0, phase=0, halt pending cleared.
